// File: rtl/ldpc_bitflip_decode.sv
// ldpc_bitflip_decode: iterative hard-decision bit-flipping LDPC decoder, H = [P^T | I].
// Define LDPC_DEC_STATS_EN to add out_iters / out_syndrome status ports.
module ldpc_bitflip_decode #(
    parameter int N        = 6,
    parameter int K        = 3,
    parameter int MAX_ITER = 4,
    parameter int ITER_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_codeword,
    input  logic [K*(N-K)-1:0]   generator_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_codeword,
    output logic [K-1:0]         out_info,
    output logic                 out_ok
`ifdef LDPC_DEC_STATS_EN
    ,
    output logic [ITER_W-1:0]    out_iters,
    output logic [N-K-1:0]       out_syndrome
`endif
);
    localparam int M  = N - K;
    localparam int CW = $clog2(M + 1);
    localparam logic [ITER_W-1:0] MAX_I = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {IDLE, SYND, FLIP, DONE} state_t;

    state_t              r_state;
    logic [N-1:0]        r_cw;
    logic [K*M-1:0]      r_p;
    logic [ITER_W-1:0]   r_iter;
    logic [M-1:0]        r_syn;
    logic [N-1:0]        r_out_cw;
    logic                r_out_valid;
    logic                r_ok;
    logic [M-1:0]        w_syn;
    logic [CW-1:0]       w_cnt [N];
    logic [CW-1:0]       w_max;
    logic [N-1:0]        w_flip;

    assign in_ready     = (r_state == IDLE) && !rst;
    assign out_valid    = r_out_valid;
    assign out_codeword = r_out_cw;
    assign out_info     = r_out_cw[N-1:M];
    assign out_ok       = r_ok;
`ifdef LDPC_DEC_STATS_EN
    assign out_iters    = r_iter;
    assign out_syndrome = r_syn;
`endif

    always_comb begin
        w_syn = r_cw[M-1:0];
        for (int j = 0; j < K; j++)
            for (int i = 0; i < M; i++)
                w_syn[i] = w_syn[i] ^ (r_cw[M+j] & r_p[j*M+i]);
    end

    // Flip counts use the syndrome registered in SYND, so a FLIP pass sees a stable s.
    always_comb begin
        w_max  = '0;
        w_flip = '0;
        for (int b = 0; b < M; b++)
            w_cnt[b] = CW'(r_syn[b]);
        for (int j = 0; j < K; j++) begin
            w_cnt[M+j] = '0;
            for (int i = 0; i < M; i++)
                w_cnt[M+j] = w_cnt[M+j] + CW'(r_syn[i] & r_p[j*M+i]);
        end
        for (int b = 0; b < N; b++)
            w_max = (w_cnt[b] > w_max) ? w_cnt[b] : w_max;
        for (int b = 0; b < N; b++)
            w_flip[b] = (w_cnt[b] == w_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cw        <= '0;
            r_p         <= '0;
            r_iter      <= '0;
            r_syn       <= '0;
            r_out_cw    <= '0;
            r_out_valid <= 1'b0;
            r_ok        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_cw    <= in_codeword;
                    r_p     <= generator_p;
                    r_iter  <= '0;
                    r_state <= SYND;
                end
                SYND: begin
                    r_syn <= w_syn;
                    if (w_syn == '0 || r_iter == MAX_I) begin
                        r_out_cw    <= r_cw;
                        r_ok        <= (w_syn == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= FLIP;
                    end
                end
                FLIP: begin
                    r_cw    <= r_cw ^ w_flip;
                    r_iter  <= r_iter + 1'b1;
                    r_state <= SYND;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_bitflip_decode.sv
// tb_ldpc_bitflip_decode: scoreboard bench for ldpc_bitflip_decode (N=6, K=3, MAX_ITER=1).
module tb_ldpc_bitflip_decode;
    localparam int N = 6, K = 3, M = 3, MAX_ITER = 1;
    localparam logic [8:0] P = 9'h1AB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_codeword = '0;
    logic [8:0]     generator_p = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   out_codeword;
    logic [K-1:0]   out_info;
    logic           out_ok;
`ifdef LDPC_DEC_STATS_EN
    logic [3:0]     out_iters;
    logic [M-1:0]   out_syndrome;
`endif

    ldpc_bitflip_decode #(.N(N), .K(K), .MAX_ITER(MAX_ITER), .ITER_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_codeword(in_codeword), .generator_p(generator_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
        .out_info(out_info), .out_ok(out_ok)
`ifdef LDPC_DEC_STATS_EN
        , .out_iters(out_iters), .out_syndrome(out_syndrome)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] cw;
        logic         ok;
        int           lat;
        int           it;
        logic [M-1:0] syn;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] synd(input logic [N-1:0] c, input logic [8:0] p);
        logic [M-1:0] s;
        s = c[M-1:0];
        for (int j = 0; j < K; j++)
            if (c[M+j]) s = s ^ p[j*M +: M];
        return s;
    endfunction

    // Reference: column view of H, unsatisfied-check count per bit = popcount(column & s).
    function automatic exp_t model(input logic [N-1:0] c0, input logic [8:0] p);
        exp_t         e;
        logic [N-1:0] c;
        logic [M-1:0] s;
        logic [M-1:0] col;
        int           cnt [N];
        int           mx;
        int           it;
        c  = c0;
        it = 0;
        s  = synd(c, p);
        for (int k = 0; k <= MAX_ITER; k++) begin
            s  = synd(c, p);
            it = k;
            if (s == '0 || k == MAX_ITER) break;
            mx = 0;
            for (int b = 0; b < N; b++) begin
                col    = (b < M) ? M'(1 << b) : p[(b-M)*M +: M];
                cnt[b] = $countones(col & s);
                if (cnt[b] > mx) mx = cnt[b];
            end
            for (int b = 0; b < N; b++)
                if (cnt[b] == mx) c[b] = ~c[b];
        end
        e.cw  = c;
        e.ok  = (s == '0);
        e.lat = 1 + 2 * it;
        e.it  = it;
        e.syn = s;
        return e;
    endfunction

    task automatic run(input logic [N-1:0] c, input int hold);
        exp_t e;
        int   lat;
        sb.push_back(model(c, P));
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_codeword = c;
        generator_p = P;
        @(negedge clk);
        in_valid    = 1'b0;
        in_codeword = N'($urandom);
        generator_p = 9'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            in_codeword = N'($urandom);
            generator_p = 9'($urandom);
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("out_codeword", 32'(out_codeword), 32'(e.cw));
        chk("out_info", 32'(out_info), 32'(e.cw[N-1:M]));
        chk("out_ok", 32'(out_ok), 32'(e.ok));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
`ifdef LDPC_DEC_STATS_EN
        chk("out_iters", 32'(out_iters), e.it);
        chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
`endif
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_codeword", 32'(out_codeword), 32'(e.cw));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [K-1:0] info;
        logic [N-1:0] c;
        int           fb;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_codeword", 32'(out_codeword), 32'd0);
        chk("rst_out_ok", 32'(out_ok), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        run(6'h15, 0);
        run(6'h1D, 0);
        run(6'h14, 0);
        run(6'h1D, 5);

        // Reset one cycle after accept drops the word.
        @(negedge clk);
        in_valid    = 1'b1;
        in_codeword = 6'h1D;
        generator_p = P;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_codeword", 32'(out_codeword), 32'd0);
        chk("midrst_out_info", 32'(out_info), 32'd0);
        chk("midrst_out_ok", 32'(out_ok), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
        run(6'h15, 0);

        for (int r = 0; r < 12; r++) begin
            info = K'($urandom);
            c    = {info, synd({info, 3'b000}, P)};
            fb   = $urandom_range(0, N);
            if (fb < N) c[fb] = ~c[fb];
            run(c, r % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ldpc_bitflip_decode.md
# ldpc_bitflip_decode

Iterative hard-decision LDPC decoder using Gallager-style bit flipping. It is the receive-side counterpart of the systematic encoder, which produces `{info_bits, check_bits}`. The block accepts an N-bit codeword and the same K×(N−K) generator P sub-matrix, and iterates syndrome/flip passes until the syndrome is zero or the iteration cap is hit. It then returns the corrected codeword, the K info bits and a success flag over a valid/ready handshake.

## Interface
- `N`, default 6: codeword length.
- `K`, default 3: info bits.
- `MAX_ITER`, default 4: maximum flip iterations (≥0).
- `ITER_W`, default 4: iteration counter width; must hold MAX_ITER.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  codeword/matrix present.
- `in_ready`  out  1  block can accept.
- `in_codeword`  in  N  received hard bits; info at [N-1:N-K], check i at [i].
- `generator_p`  in  K*(N-K)  P[j][i] at bit j*(N-K)+i.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `out_codeword`  out  N  corrected codeword.
- `out_info`  out  K  `out_codeword[N-1:N-K]`.
- `out_ok`  out  1  1 = final syndrome zero.

## Operation
- Parity-check matrix H = [Pᵀ | I]. Check i covers info bit j (codeword bit N-K+j) when P[j][i]=1, plus check bit i (codeword bit i).
- Syndrome s[i] = XOR of all covered codeword bits.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid&&in_ready`, register codeword and P, clear iter, go to SYND.
  - SYND: compute s combinationally and register it.
    - s==0: go to DONE with ok=1.
    - else if iter==MAX_ITER: go to DONE with ok=0.
    - else: go to FLIP.
  - FLIP: for each bit b, cnt[b] = number of unsatisfied checks covering b. Let m = max cnt. Flip every bit with cnt[b]==m (m>0 is guaranteed). iter+=1. Go to SYND.
  - DONE: `out_valid`=1; outputs held stable. On `out_ready`, go to IDLE.
- cnt width is clog2(N-K+1); all counts are unsigned; ties flip all tied bits.
- Registered P and codeword are ignored by the input port until the next accept; input changes mid-decode have no effect.
- `out_ok`=1 means only that the syndrome is zero; a zero syndrome on a wrong codeword is reported as ok.

## Timing
- Reset values:
  - state IDLE, `out_valid`=0, `out_codeword`=0, `out_info`=0, `out_ok`=0, iter=0.
  - `in_ready`=0 while `rst` is high, 1 on the first cycle after.
- Latency from the accept edge to `out_valid` high is 1+2·F cycles, where F = flips performed (0..MAX_ITER).
  - Clean word: 1 cycle.
  - Worst case: 1+2·MAX_ITER cycles.
- `in_ready` is low in SYND/FLIP/DONE; no accept while busy.
- `out_valid` holds until `out_ready`. The handshake edge returns to IDLE; `in_ready` rises the next cycle, so there is one bubble cycle between words.
- `out_ready` has no effect outside DONE.
- `rst` mid-decode: next cycle is IDLE with outputs at reset values; the in-flight word is dropped with no output.
- MAX_ITER=0: the block only checks the syndrome, with latency 1.

## Configuration
- `LDPC_DEC_STATS_EN` defined:
  - Adds port `out_iters` (out, ITER_W): iterations used, valid with `out_valid`, reset 0.
  - Adds port `out_syndrome` (out, N-K): final registered syndrome, reset 0.
- Undefined: neither port exists and the related registers are not built; decode behaviour is identical.

## Test plan
All scenarios use N=6, K=3, MAX_ITER=1, `generator_p`=9'h1AB (P rows 011, 101, 110).
- Clean word: accept 6'h15 -> `out_valid` 1 cycle after accept; `out_codeword`=6'h15, `out_info`=3'b010, `out_ok`=1.
- Single info-bit error: accept 6'h1D (bit 3 flipped) -> `out_valid` after 3 cycles; `out_codeword`=6'h15, `out_info`=3'b010, `out_ok`=1.
- Uncorrectable: accept 6'h14 (check bit 0 flipped) -> `out_valid` after 3 cycles; `out_ok`=0. With `LDPC_DEC_STATS_EN`: `out_iters`=1, `out_syndrome` nonzero.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> outputs stable, `in_ready`=0 throughout. Raise `out_ready` -> `in_ready`=1 on the cycle after the handshake.
- Reset mid-decode: assert `rst` one cycle after accepting 6'h1D -> next cycle `out_valid`=0, all outputs 0, `in_ready`=1 after release. A following 6'h15 decodes normally.
- Input change while busy: change `in_codeword` and `generator_p` during FLIP -> the result matches the originally accepted word.
